// File: rtl/fifo_pkg.sv
// Shared types and default sizes for the FIFO controller slice.
package fifo_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 5;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_PARTIAL,
      ST_FULL
   } fifo_state_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer with enable; MSB is the wrap bit of a FIFO pointer.
module fifo_ptr #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         en,
   output logic [W-1:0] ptr
);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ptr <= '0;
      end else if (en) begin
         ptr <= ptr + W'(1);
      end
   end

endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller driving an external dual-port memory
// with one-cycle registered read latency.
module fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int AFULL_LVL  = 2**ADDR_WIDTH - 2,
   parameter int AEMPTY_LVL = 2
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rvalid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  mem_we,
   output logic                  mem_re,
   output logic [ADDR_WIDTH-1:0] mem_waddr,
   output logic [ADDR_WIDTH-1:0] mem_raddr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] LAST  = PW'(2**ADDR_WIDTH - 1);
   localparam logic [PW-1:0] ONE   = PW'(1);
   localparam logic [PW-1:0] AF_C  = PW'(AFULL_LVL);
   localparam logic [PW-1:0] AE_C  = PW'(AEMPTY_LVL);

   fifo_state_t   state;
   fifo_state_t   st_nxt;
   logic          push_acc;
   logic          pop_acc;
   logic          push_only;
   logic          pop_only;
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [PW-1:0] wptr_nxt;
   logic [PW-1:0] rptr_nxt;
   logic [PW-1:0] count_nxt;

   assign push_acc  = push & ~full;
   assign pop_acc   = pop & ~empty;
   assign push_only = push_acc & ~pop_acc;
   assign pop_only  = pop_acc & ~push_acc;

   // Gated by rstn so the strobes drop the moment reset asserts.
   assign mem_we    = push_acc & rstn;
   assign mem_re    = pop_acc & rstn;
   assign mem_waddr = wptr[ADDR_WIDTH-1:0];
   assign mem_raddr = rptr[ADDR_WIDTH-1:0];
   assign mem_wdata = wdata;
   assign rdata     = mem_rdata;

   fifo_ptr #(.W(PW)) u_wptr (
      .clk  (clk),
      .rstn (rstn),
      .en   (push_acc),
      .ptr  (wptr)
   );

   fifo_ptr #(.W(PW)) u_rptr (
      .clk  (clk),
      .rstn (rstn),
      .en   (pop_acc),
      .ptr  (rptr)
   );

   assign wptr_nxt  = wptr + PW'(push_acc);
   assign rptr_nxt  = rptr + PW'(pop_acc);
   assign count_nxt = wptr_nxt - rptr_nxt;

   always_comb begin
      st_nxt = state;
      case (state)
         ST_EMPTY: begin
            if (push_only) st_nxt = ST_PARTIAL;
         end
         ST_PARTIAL: begin
            if (push_only && count == LAST)
               st_nxt = ST_FULL;
            else if (pop_only && count == ONE)
               st_nxt = ST_EMPTY;
         end
         ST_FULL: begin
            if (pop_acc) st_nxt = ST_PARTIAL;
         end
         default: st_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= ST_EMPTY;
         empty        <= 1'b1;
         full         <= 1'b0;
         count        <= '0;
         almost_empty <= 1'b1;
         almost_full  <= 1'b0;
         rvalid       <= 1'b0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         state        <= st_nxt;
         empty        <= (st_nxt == ST_EMPTY);
         full         <= (st_nxt == ST_FULL);
         count        <= count_nxt;
         almost_empty <= (count_nxt <= AE_C);
         almost_full  <= (count_nxt >= AF_C);
         rvalid       <= pop_acc;
         overflow     <= push & full;
         underflow    <= pop & empty;
      end
   end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl with a behavioural registered-read memory.
module tb_fifo_ctrl;

   localparam int DW    = 8;
   localparam int AW    = 5;
   localparam int DEPTH = 2**AW;

   logic          clk = 1'b0;
   logic          rstn;
   logic          push;
   logic [DW-1:0] wdata;
   logic          pop;
   logic [DW-1:0] rdata;
   logic          rvalid;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic [AW:0]   count;
   logic          overflow;
   logic          underflow;
   logic          mem_we;
   logic          mem_re;
   logic [AW-1:0] mem_waddr;
   logic [AW-1:0] mem_raddr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   logic [DW-1:0] mem [DEPTH];

   int            n_tests = 0;
   int            n_fail  = 0;
   int            m_count = 0;
   logic [AW:0]   m_wptr  = '0;
   logic [AW:0]   m_rptr  = '0;
   logic [DW-1:0] data_q[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] dval    = 8'h40;

   always #5 clk = ~clk;

   fifo_ctrl #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .push         (push),
      .wdata        (wdata),
      .pop          (pop),
      .rdata        (rdata),
      .rvalid       (rvalid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow),
      .mem_we       (mem_we),
      .mem_re       (mem_re),
      .mem_waddr    (mem_waddr),
      .mem_raddr    (mem_raddr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_raddr];
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_flags();
      chk("count", 32'(count), 32'(m_count));
      chk("empty", 32'(empty), 32'(m_count == 0));
      chk("full", 32'(full), 32'(m_count == DEPTH));
      chk("afull", 32'(almost_full), 32'(m_count >= DEPTH - 2));
      chk("aempty", 32'(almost_empty), 32'(m_count <= 2));
   endtask

   // One clock of stimulus; call just after a rising edge.
   task automatic step(input logic p, input logic [DW-1:0] d,
                       input logic r);
      logic pa;
      logic pp;
      pa = p && (m_count < DEPTH);
      pp = r && (m_count > 0);
      push  = p;
      wdata = d;
      pop   = r;
      #1;
      chk("mem_we", 32'(mem_we), 32'(pa));
      chk("mem_re", 32'(mem_re), 32'(pp));
      if (pa) chk("waddr", 32'(mem_waddr), 32'(m_wptr[AW-1:0]));
      if (pp) chk("raddr", 32'(mem_raddr), 32'(m_rptr[AW-1:0]));
      if (pp) begin
         exp_q.push_back(data_q.pop_front());
         m_rptr = m_rptr + 1'b1;
      end
      if (pa) begin
         data_q.push_back(d);
         m_wptr = m_wptr + 1'b1;
      end
      m_count = m_count + int'(pa) - int'(pp);
      @(posedge clk);
      #1;
      push = 1'b0;
      pop  = 1'b0;
      chk_flags();
      chk("rvalid", 32'(rvalid), 32'(pp));
      chk("overflow", 32'(overflow), 32'(p && !pa));
      chk("underflow", 32'(underflow), 32'(r && !pp));
      if (rvalid) begin
         if (exp_q.size() == 0)
            chk("rvalid_extra", 32'(rvalid), 32'(0));
         else
            chk("rdata", 32'(rdata), 32'(exp_q.pop_front()));
      end
   endtask

   task automatic push_n(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b1, dval, 1'b0);
         dval = dval + 8'd1;
      end
   endtask

   task automatic pop_n(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
   endtask

   initial begin
      rstn  = 1'b0;
      push  = 1'b0;
      pop   = 1'b0;
      wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      push = 1'b1;
      #1;
      chk("rst_mem_we", 32'(mem_we), 32'(0));
      push = 1'b0;
      chk_flags();
      chk("rst_rvalid", 32'(rvalid), 32'(0));
      chk("rst_ovf", 32'(overflow), 32'(0));
      chk("rst_unf", 32'(underflow), 32'(0));
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      step(1'b1, 8'h11, 1'b0);
      step(1'b1, 8'h22, 1'b0);
      step(1'b1, 8'h33, 1'b0);
      pop_n(3);
      chk("end_empty", 32'(empty), 32'(1));

      step(1'b0, 8'h00, 1'b1);
      step(1'b1, 8'h5a, 1'b1);
      chk("pp_empty_cnt", 32'(count), 32'(1));
      pop_n(1);

      push_n(DEPTH);
      chk("full32", 32'(full), 32'(1));
      step(1'b1, 8'hee, 1'b0);
      chk("ovf_cnt", 32'(count), 32'(DEPTH));

      step(1'b1, 8'hdd, 1'b1);
      chk("full_pp_cnt", 32'(count), 32'(DEPTH - 1));

      pop_n(DEPTH - 1 - 16);
      for (int i = 0; i < 100; i++) begin
         step(1'b1, dval, 1'b1);
         dval = dval + 8'd3;
      end
      chk("wrap_cnt", 32'(count), 32'(16));

      pop_n(6);
      #2;
      rstn = 1'b0;
      #1;
      data_q.delete();
      exp_q.delete();
      m_count = 0;
      m_wptr  = '0;
      m_rptr  = '0;
      chk("async_cnt", 32'(count), 32'(0));
      chk("async_empty", 32'(empty), 32'(1));
      chk("async_rvalid", 32'(rvalid), 32'(0));
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      step(1'b0, 8'h00, 1'b1);
      push_n(4);
      for (int i = 0; i < 20; i++)
         step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)));
      pop_n(m_count);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
